// File: rtl/delay_pkg.sv
// Shared constants and types for the single-clock delay block.
package delay_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage

// File: rtl/en_reg.sv
// Enabled register with synchronous active-high reset and a parameterised reset value.
module en_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Reset wins over enable so a stalled pipeline still clears.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/delay_single_clock.sv
// One-enabled-clock delay of a data word and its valid bit, plus a one-cycle change flag.
module delay_single_clock
  import delay_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_changed
);

  logic [WIDTH-1:0] w_data_q;
  logic             w_valid_q;
  logic             w_differs;
  logic             r_changed;

  en_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_data_reg (
    .clk   (clk),
    .n_rst (n_rst),
    .i_en  (en),
    .i_d   (in),
    .o_q   (w_data_q)
  );

  // in_valid rides alongside the data; it never gates the data capture.
  en_reg #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_valid_reg (
    .clk   (clk),
    .n_rst (n_rst),
    .i_en  (en),
    .i_d   (in_valid),
    .o_q   (w_valid_q)
  );

  assign w_differs = (in != w_data_q);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= en & w_differs;
    end
  end

  assign out         = w_data_q;
  assign out_valid   = w_valid_q;
  assign out_changed = r_changed;

endmodule

// File: tb/tb_delay_single_clock.sv
// Scoreboarded bench for delay_single_clock at WIDTH=32 and WIDTH=8.
module tb_delay_single_clock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        en;
  logic        in_valid;
  logic [31:0] in32;
  logic [7:0]  in8;
  logic [31:0] out32;
  logic        ov32, oc32;
  logic [7:0]  out8;
  logic        ov8, oc8;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        v;
    logic        c;
  } exp32_t;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       c;
  } exp8_t;

  exp32_t q32[$];
  exp8_t  q8[$];

  // Reference state of what each DUT should be holding.
  logic [31:0] m32 = '0;
  logic        mv32 = 1'b0;
  logic [7:0]  m8 = '0;
  logic        mv8 = 1'b0;

  delay_single_clock #(.WIDTH(32)) dut32 (
    .clk         (clk),
    .n_rst       (n_rst),
    .in          (in32),
    .in_valid    (in_valid),
    .en          (en),
    .out         (out32),
    .out_valid   (ov32),
    .out_changed (oc32)
  );

  delay_single_clock #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .n_rst       (n_rst),
    .in          (in8),
    .in_valid    (in_valid),
    .en          (en),
    .out         (out8),
    .out_valid   (ov8),
    .out_changed (oc8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of stimulus, predict, then compare one edge later.
  task automatic step(input logic rst, input logic e, input logic iv,
                      input logic [31:0] d32, input logic [7:0] d8);
    exp32_t x32;
    exp8_t  x8;
    @(negedge clk);
    n_rst    = rst;
    en       = e;
    in_valid = iv;
    in32     = d32;
    in8      = d8;
    if (rst) begin
      x32 = '{d: 32'd0, v: 1'b0, c: 1'b0};
      x8  = '{d: 8'd0,  v: 1'b0, c: 1'b0};
    end else if (e) begin
      x32 = '{d: d32, v: iv, c: (d32 != m32)};
      x8  = '{d: d8,  v: iv, c: (d8 != m8)};
    end else begin
      x32 = '{d: m32, v: mv32, c: 1'b0};
      x8  = '{d: m8,  v: mv8,  c: 1'b0};
    end
    m32 = x32.d; mv32 = x32.v;
    m8  = x8.d;  mv8  = x8.v;
    q32.push_back(x32);
    q8.push_back(x8);
    @(posedge clk);
    #1;
    x32 = q32.pop_front();
    x8  = q8.pop_front();
    check("sb32_out",     64'(out32), 64'(x32.d));
    check("sb32_valid",   64'(ov32),  64'(x32.v));
    check("sb32_changed", 64'(oc32),  64'(x32.c));
    check("sb8_out",      64'(out8),  64'(x8.d));
    check("sb8_valid",    64'(ov8),   64'(x8.v));
    check("sb8_changed",  64'(oc8),   64'(x8.c));
    $display("step rst=%0b en=%0b iv=%0b in32=%0d -> out32=%0d ov=%0b oc=%0b | in8=%0h -> out8=%0h",
             rst, e, iv, d32, out32, ov32, oc32, d8, out8);
  endtask

  initial begin
    n_rst    = 1'b1;
    en       = 1'b1;
    in_valid = 1'b0;
    in32     = 32'd10034;
    in8      = 8'h00;

    // Reset with en high: reset takes priority.
    step(1'b1, 1'b1, 1'b0, 32'd10034, 8'h00);
    check("rst_out",     64'(out32), 64'd0);
    check("rst_valid",   64'(ov32),  64'd0);
    check("rst_changed", 64'(oc32),  64'd0);

    step(1'b0, 1'b1, 1'b1, 32'd10034, 8'hFF);
    check("first_out",     64'(out32), 64'd10034);
    check("first_valid",   64'(ov32),  64'd1);
    check("first_changed", 64'(oc32),  64'd1);
    check("w8_ff_out",     64'(out8),  64'hFF);

    repeat (4) step(1'b0, 1'b1, 1'b1, 32'd10034, 8'hFF);
    check("hold_out",     64'(out32), 64'd10034);
    check("hold_changed", 64'(oc32),  64'd0);
    check("w8_hold_chg",  64'(oc8),   64'd0);

    step(1'b0, 1'b1, 1'b1, 32'd99009900, 8'h5A);
    check("new_out",     64'(out32), 64'd99009900);
    check("new_changed", 64'(oc32),  64'd1);
    step(1'b0, 1'b1, 1'b1, 32'd99009900, 8'h5A);
    check("new_settle",  64'(oc32),  64'd0);

    repeat (3) begin
      step(1'b0, 1'b0, 1'b1, 32'd5, 8'h11);
      check("stall_out",     64'(out32), 64'd99009900);
      check("stall_changed", 64'(oc32),  64'd0);
    end
    step(1'b0, 1'b1, 1'b1, 32'd5, 8'h11);
    check("resume_out", 64'(out32), 64'd5);

    // Reset while stalled.
    step(1'b1, 1'b0, 1'b1, 32'd7, 8'h22);
    check("rst_stall_out",   64'(out32), 64'd0);
    check("rst_stall_valid", 64'(ov32),  64'd0);

    // in_valid low does not block capture.
    step(1'b0, 1'b1, 1'b0, 32'd123, 8'h33);
    check("iv0_out",   64'(out32), 64'd123);
    check("iv0_valid", 64'(ov32),  64'd0);

    // Mid-cycle reset must not disturb outputs before the next edge.
    #2;
    n_rst = 1'b1;
    #1;
    check("midrst_out",   64'(out32), 64'd123);
    check("midrst_valid", 64'(ov32),  64'd0);
    step(1'b1, 1'b1, 1'b1, 32'd9, 8'h44);
    check("midrst_edge", 64'(out32), 64'd0);

    // No dead cycle after reset release.
    step(1'b0, 1'b1, 1'b1, 32'd77, 8'h55);
    check("post_rst_out", 64'(out32), 64'd77);

    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? m32 : $urandom,
           ($urandom_range(0, 3) == 0) ? m8 : 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_single_clock.md
DELAY_SINGLE_CLOCK -- requirements
Module: delay_single_clock

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (name the clock and reset ports as the codebase does: clk, n_rst; polarity and synchronicity are fixed).
REQ-002 Parameter WIDTH, default 32, data path width in bits, legal range 1..64.
REQ-003 Parameter RESET_VAL, default all-zeros, value loaded into out on reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 n_rst  input  1  synchronous active-high reset; 1 sampled at a rising edge clears state; port name kept for codebase consistency.
REQ-006 in  input  WIDTH  data to be delayed.
REQ-007 in_valid  input  1  qualifier for in.
REQ-008 en  input  1  capture enable; 0 = hold (stall).
REQ-009 out  output  WIDTH  in delayed by exactly one enabled clock.
REQ-010 out_valid  output  1  in_valid delayed alongside out.
REQ-011 out_changed  output  1  high for one cycle when the last capture changed out's value.

Function
REQ-012 At a rising edge with n_rst=0 and en=1, out SHALL take the value in held just before that edge; latency is one clock, with no combinational in->out path.
REQ-013 At the same edge, out_valid SHALL take in_valid.
REQ-014 At that edge, out_changed SHALL be 1 iff the new out differs from the old out in any bit, and 0 otherwise.
REQ-015 With en=0 at an edge, out and out_valid SHALL hold their values and out_changed SHALL go to 0.
REQ-016 in_valid SHALL NOT gate capture: out loads in whenever en=1, regardless of in_valid.
REQ-017 A constant in SHALL leave out constant indefinitely, with out_changed=0 after the first capture.
REQ-018 All outputs SHALL be driven directly from flops (registered outputs).
REQ-019 X on in with en=1 SHALL propagate to out only; out_valid SHALL stay defined.

Reset
REQ-020 n_rst=1 at a rising edge SHALL set out=RESET_VAL, out_valid=0 and out_changed=0, with priority over en.
REQ-021 Reset SHALL take effect only at a clock edge; asserting it mid-cycle SHALL NOT change outputs before the next rising edge.
REQ-022 On the first edge with n_rst=0 and en=1 after reset, out SHALL load in; there are no dead cycles.
REQ-023 Reset asserted while en=0 SHALL still clear all state.

Structure
REQ-024 A shared package delay_pkg SHALL hold the DEFAULT_WIDTH=32 constant and the data_t typedef (logic [WIDTH-1:0]).
REQ-025 One sub-module, en_reg (enabled, synchronously reset register, parameterised width and reset value), SHALL be instantiated for the data path and again for the valid bit.
REQ-026 out_changed SHALL be a separate flop fed by a not-equal comparison of the en_reg D and Q values.

Verification
REQ-027 Reset: in=10034, n_rst=1 for one edge -> out=0, out_valid=0, out_changed=0.
REQ-028 Release reset, en=1, in=10034, in_valid=1 -> one edge later out=10034, out_valid=1, out_changed=1; after 4 more edges out=10034, out_changed=0.
REQ-029 Change in to 99009900 -> next edge out=99009900, out_changed=1; the edge after that out_changed=0.
REQ-030 en=0 for 3 edges while in=5 -> out stays 99009900; en=1 -> next edge out=5.
REQ-031 Assert n_rst with en=0 and out=5 -> next edge out=0, out_valid=0; then check in_valid=0 with en=1 still loads in into out.
REQ-032 Build with WIDTH=8, drive in=0xFF -> out=0xFF after one edge; a bench checker confirms one-edge latency on every cycle.
